// File: rtl/otter_io_responder.sv
// Peripheral end of the MCU IOBUS. It provides switch input, an LED register, a
// down-counting timer and a button edge detector. Their events drive a registered
// level interrupt. The read path is combinational; all state updates on the rising clock edge.
module otter_io_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int unsigned NUM_SW    = 16,
  parameter int unsigned NUM_LED   = 16,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        iobus_addr,
  input  logic [31:0]        iobus_out,
  input  logic               iobus_wr,
  output logic [31:0]        iobus_in,
  input  logic [NUM_SW-1:0]  sw,
  input  logic               btn,
  output logic [NUM_LED-1:0] leds,
  output logic               intr
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [31:0] ADDR_SW    = BASE_ADDR + 32'h00;
  localparam logic [31:0] ADDR_LED   = BASE_ADDR + 32'h20;
  localparam logic [31:0] ADDR_CTRL  = BASE_ADDR + 32'h40;
  localparam logic [31:0] ADDR_LOAD  = BASE_ADDR + 32'h44;
  localparam logic [31:0] ADDR_COUNT = BASE_ADDR + 32'h48;
  localparam logic [31:0] ADDR_STAT  = BASE_ADDR + 32'h4C;

  logic [NUM_SW-1:0]  sw_s1, sw_s2;
  logic               btn_s1, btn_s2, btn_d, btn_dd;
  logic [NUM_LED-1:0] led_q;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [31:0]        load_q;
  logic [31:0]        count_q, count_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               tif_q, tif_d, bif_q, bif_d;
  logic               intr_q, intr_d;

  logic [31:0] addr_w;
  logic        wr_led, wr_ctrl, wr_load, wr_stat;
  logic        ten, arl, tick, tif_set, btn_rise;

  // Word address: the byte-lane bits are masked off so they never affect decode
  assign addr_w  = iobus_addr & ~32'h3;
  assign wr_led  = iobus_wr && (addr_w == ADDR_LED);
  assign wr_ctrl = iobus_wr && (addr_w == ADDR_CTRL);
  assign wr_load = iobus_wr && (addr_w == ADDR_LOAD);
  assign wr_stat = iobus_wr && (addr_w == ADDR_STAT);

  assign ten      = ctrl_q[0];
  assign arl      = ctrl_q[1];
  assign tick     = ten && (presc_q == PW'(PRESCALE - 1));
  assign btn_rise = btn_d & ~btn_dd;

  assign leds = led_q;
  assign intr = intr_q;

  // Input synchronisers plus the extra button stage used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_d  <= 1'b0;
      btn_dd <= 1'b0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
      btn_dd <= btn_d;
    end
  end

  // Next-state logic for the timer, control, status and interrupt
  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = count_q;
    presc_d = presc_q;
    tif_set = 1'b0;

    if (!ten || tick) presc_d = '0;
    else              presc_d = presc_q + PW'(1);

    if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        tif_set = 1'b1;
        if (arl) count_d = load_q;
        else     ctrl_d[0] = 1'b0;
      end
    end

    // A software write sets control. Enabling from idle restarts the count, and disabling freezes it.
    if (wr_ctrl) begin
      ctrl_d = iobus_out[3:0];
      if (iobus_out[0] && !ten) begin
        count_d = load_q;
        presc_d = '0;
      end else if (!iobus_out[0]) begin
        count_d = count_q;
        presc_d = '0;
      end
    end

    // W1C with hardware set winning over a same-edge clear
    tif_d  = (tif_q & ~(wr_stat & iobus_out[0])) | tif_set;
    bif_d  = (bif_q & ~(wr_stat & iobus_out[1])) | btn_rise;
    intr_d = (tif_q & ctrl_q[2]) | (bif_q & ctrl_q[3]);
  end

  // Architectural register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      tif_q   <= 1'b0;
      bif_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      if (wr_led)  led_q  <= iobus_out[NUM_LED-1:0];
      if (wr_load) load_q <= iobus_out;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tif_q   <= tif_d;
      bif_q   <= bif_d;
      intr_q  <= intr_d;
    end
  end

  // Combinational read mux; unmapped addresses read zero
  always_comb begin
    iobus_in = 32'h0;
    if      (addr_w == ADDR_SW)    iobus_in = 32'(sw_s2);
    else if (addr_w == ADDR_LED)   iobus_in = 32'(led_q);
    else if (addr_w == ADDR_CTRL)  iobus_in = 32'(ctrl_q);
    else if (addr_w == ADDR_LOAD)  iobus_in = load_q;
    else if (addr_w == ADDR_COUNT) iobus_in = count_q;
    else if (addr_w == ADDR_STAT)  iobus_in = {30'h0, bif_q, tif_q};
  end

endmodule

// File: tb/tb_otter_io_responder.sv
// Self-checking bench for otter_io_responder: register-map vector table plus
// hand-written timer, button and reset sequences.
module tb_otter_io_responder;

  localparam logic [31:0] B = 32'h1100_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iobus_addr, iobus_out, iobus_in;
  logic        iobus_wr;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] leds;
  logic        intr;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;  // write data, or expected read data
    string       name;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  otter_io_responder #(
    .BASE_ADDR(B), .NUM_SW(16), .NUM_LED(16), .PRESCALE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .iobus_addr(iobus_addr), .iobus_out(iobus_out),
    .iobus_wr(iobus_wr), .iobus_in(iobus_in), .sw(sw), .btn(btn),
    .leds(leds), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive a read address, queue the expectation, compare once the mux settles
  task automatic rd_check(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    string       n;
    iobus_addr = addr;
    iobus_wr   = 1'b0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    chk(n, iobus_in, e);
  endtask

  // One-cycle write strobe; returns on the falling edge after the write edge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    iobus_addr = addr;
    iobus_out  = data;
    iobus_wr   = 1'b1;
    @(negedge clk);
    iobus_wr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, B + 32'h00, 32'h0000_A5A5, "sw_read"};
    vecs[1]  = '{1'b0, B + 32'h10, 32'h0000_0000, "unmapped_10"};
    vecs[2]  = '{1'b0, B + 32'h20, 32'h0000_0000, "led_reset"};
    vecs[3]  = '{1'b0, B + 32'h40, 32'h0000_0000, "ctrl_reset"};
    vecs[4]  = '{1'b0, B + 32'h48, 32'h0000_0000, "count_reset"};
    vecs[5]  = '{1'b0, B + 32'h4C, 32'h0000_0000, "stat_reset"};
    vecs[6]  = '{1'b0, 32'h1200_0000, 32'h0000_0000, "out_of_window"};
    vecs[7]  = '{1'b1, B + 32'h20, 32'hFFFF_1234, "w_led"};
    vecs[8]  = '{1'b0, B + 32'h20, 32'h0000_1234, "led_readback"};
    vecs[9]  = '{1'b1, B + 32'h00, 32'hDEAD_BEEF, "w_sw_ro"};
    vecs[10] = '{1'b0, B + 32'h20, 32'h0000_1234, "led_after_ro_write"};
    vecs[11] = '{1'b0, B + 32'h00, 32'h0000_A5A5, "sw_after_ro_write"};
    vecs[12] = '{1'b1, B + 32'h44, 32'hCAFE_F00D, "w_load"};
    vecs[13] = '{1'b0, B + 32'h44, 32'hCAFE_F00D, "load_readback"};
    vecs[14] = '{1'b0, B + 32'h47, 32'hCAFE_F00D, "load_low_bits_ignored"};
    vecs[15] = '{1'b1, B + 32'h48, 32'h0000_0123, "w_count_ro"};
    vecs[16] = '{1'b0, B + 32'h48, 32'h0000_0000, "count_after_ro_write"};
    vecs[17] = '{1'b1, B + 32'h40, 32'hFFFF_FFFA, "w_ctrl_mask"};
    vecs[18] = '{1'b0, B + 32'h40, 32'h0000_000A, "ctrl_masked"};
    vecs[19] = '{1'b1, B + 32'h40, 32'h0000_0000, "w_ctrl_clear"};
    vecs[20] = '{1'b0, B + 32'h40, 32'h0000_0000, "ctrl_cleared"};

    rst_n = 1'b0; iobus_addr = '0; iobus_out = '0; iobus_wr = 1'b0;
    sw = 16'hA5A5; btn = 1'b0;
    #2;
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_intr", 32'(intr), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Register map vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else            rd_check(vecs[i].addr, vecs[i].data, vecs[i].name);
    end
    chk("leds_port", 32'(leds), 32'h0000_1234);

    // One-shot countdown
    bus_write(B + 32'h44, 32'd3);
    bus_write(B + 32'h40, 32'h5);
    rd_check(B + 32'h48, 32'd3, "count_3");
    @(negedge clk); rd_check(B + 32'h48, 32'd2, "count_2");
    @(negedge clk); rd_check(B + 32'h48, 32'd1, "count_1");
    @(negedge clk); rd_check(B + 32'h48, 32'd0, "count_0");
    @(negedge clk);
    rd_check(B + 32'h4C, 32'h1, "tif_fired");
    rd_check(B + 32'h40, 32'h4, "ten_cleared");
    chk("intr_not_yet", 32'(intr), 32'h0);
    @(negedge clk);
    chk("intr_timer", 32'(intr), 32'h1);
    rd_check(B + 32'h48, 32'd0, "count_holds_0");
    bus_write(B + 32'h4C, 32'h1);
    rd_check(B + 32'h4C, 32'h0, "tif_w1c");
    chk("intr_still_1", 32'(intr), 32'h1);
    @(negedge clk);
    chk("intr_drop_after_clear", 32'(intr), 32'h0);

    // LOAD=0 auto-reload fires every tick; same-edge set beats clear
    bus_write(B + 32'h44, 32'd0);
    bus_write(B + 32'h40, 32'h7);
    rd_check(B + 32'h4C, 32'h0, "tif_before_first_tick");
    @(negedge clk);
    rd_check(B + 32'h4C, 32'h1, "tif_every_tick");
    bus_write(B + 32'h4C, 32'h1);
    rd_check(B + 32'h4C, 32'h1, "set_wins_over_clear");
    chk("intr_arl", 32'(intr), 32'h1);
    bus_write(B + 32'h40, 32'h3);
    @(negedge clk);
    chk("intr_tie_off", 32'(intr), 32'h0);
    bus_write(B + 32'h40, 32'h0);
    bus_write(B + 32'h4C, 32'h1);
    rd_check(B + 32'h4C, 32'h0, "tif_cleared_stopped");

    // Button edge: BIF on the 4th edge after the rise, INTR one edge later
    bus_write(B + 32'h40, 32'h8);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    rd_check(B + 32'h4C, 32'h0, "bif_edge3");
    @(negedge clk);
    rd_check(B + 32'h4C, 32'h2, "bif_edge4");
    chk("intr_btn_not_yet", 32'(intr), 32'h0);
    @(negedge clk);
    chk("intr_btn", 32'(intr), 32'h1);
    bus_write(B + 32'h4C, 32'h2);
    rd_check(B + 32'h4C, 32'h0, "bif_w1c");
    @(negedge clk);
    chk("intr_btn_drop", 32'(intr), 32'h0);

    // Running timer with a pending button interrupt, then async reset between edges
    btn = 1'b0;
    repeat (4) @(negedge clk);
    btn = 1'b1;
    repeat (5) @(negedge clk);
    bus_write(B + 32'h44, 32'd10);
    bus_write(B + 32'h40, 32'hD);
    rd_check(B + 32'h48, 32'd10, "count_load_10");
    bus_write(B + 32'h40, 32'hD);
    rd_check(B + 32'h48, 32'd8, "no_reload_on_rewrite");
    repeat (3) @(negedge clk);
    rd_check(B + 32'h48, 32'd5, "count_5");
    chk("intr_pending", 32'(intr), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_intr", 32'(intr), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    rd_check(B + 32'h48, 32'd0, "rst_count");
    rd_check(B + 32'h40, 32'd0, "rst_ctrl");
    rd_check(B + 32'h4C, 32'd0, "rst_stat");
    btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    rd_check(B + 32'h48, 32'd0, "post_rst_count");
    rd_check(B + 32'h40, 32'd0, "post_rst_ctrl");
    rd_check(B + 32'h4C, 32'd0, "post_rst_stat");
    chk("post_rst_intr", 32'(intr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
